// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK flip-flop bank controller.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DWELL = 2'd2
    } state_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            default: nxt = ~q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Arbitrated JK update sequencer for a shared flip-flop bank with post-update dwell lock.
module jk_bank_ctrl
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned DW    = 4,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*WIDTH-1:0] req_j,
    input  logic [NREQ*WIDTH-1:0] req_k,
    input  logic [NREQ*DW-1:0]   req_dwell,
    input  logic                 sync_clr,
    input  logic                 sync_preset,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qbar,
    output logic                 busy,
    output logic                 done,
    output logic [IW-1:0]        done_id
);

    state_e           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [DW-1:0]    dwell_q, dwell_d, cnt_q, cnt_d;
    logic [IW-1:0]    id_q, id_d;
    logic [WIDTH-1:0] bank_q, bank_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IW-1:0]    done_id_q, done_id_d;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        j_d       = j_q;
        k_d       = k_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        bank_d    = bank_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    j_d      = req_j[32'(gnt_idx) * WIDTH +: WIDTH];
                    k_d      = req_k[32'(gnt_idx) * WIDTH +: WIDTH];
                    dwell_d  = req_dwell[32'(gnt_idx) * DW +: DW];
                    id_d     = gnt_idx;
                    rr_ptr_d = IW'((32'(gnt_idx) + 1) % NREQ);
                    state_d  = APPLY;
                    busy_d   = 1'b1;
                end
            end
            APPLY: begin
                for (int unsigned b = 0; b < WIDTH; b++) begin
                    bank_d[b] = jk_next(bank_q[b], j_q[b], k_q[b]);
                end
                if (dwell_q != '0) begin
                    state_d = DWELL;
                    cnt_d   = dwell_q;
                end else begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end
            end
            DWELL: begin
                cnt_d = cnt_q - DW'(1);
                if (cnt_q == DW'(1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Bank-wide overrides win over any JK update but leave sequencing untouched.
        if (sync_clr) begin
            bank_d = '0;
        end else if (sync_preset) begin
            bank_d = '1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            j_q       <= '0;
            k_q       <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            bank_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            j_q       <= j_d;
            k_q       <= k_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            bank_q    <= bank_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign req_ready = (clr_n && state_q == IDLE) ? gnt : '0;
    assign q         = bank_q;
    assign qbar      = ~bank_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl (WIDTH=8, NREQ=2, DW=4).
module tb_jk_bank_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_j;
    logic [15:0] req_k;
    logic [7:0]  req_dwell;
    logic        sync_clr;
    logic        sync_preset;
    logic [7:0]  q;
    logic [7:0]  qbar;
    logic        busy;
    logic        done;
    logic [0:0]  done_id;

    int checks   = 0;
    int failures = 0;

    jk_bank_ctrl #(.WIDTH(8), .NREQ(2), .DW(4)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_j       (req_j),
        .req_k       (req_k),
        .req_dwell   (req_dwell),
        .sync_clr    (sync_clr),
        .sync_preset (sync_preset),
        .q           (q),
        .qbar        (qbar),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] j, input logic [7:0] k,
                           input logic [3:0] dw);
        req_j[i*8 +: 8]     = j;
        req_k[i*8 +: 8]     = k;
        req_dwell[i*4 +: 4] = dw;
    endtask

    initial begin
        clr_n       = 1'b0;
        req_valid   = 2'b11;
        req_j       = '0;
        req_k       = '0;
        req_dwell   = '0;
        sync_clr    = 1'b0;
        sync_preset = 1'b0;
        #2;
        chk("rst_q", q, 8'h00);
        chk("rst_qbar", qbar, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_done_id", done_id, 1'b0);
        chk("rst_ready_forced", req_ready, 2'b00);
        tick();
        tick();
        req_valid = 2'b00;
        clr_n     = 1'b1;

        // Single command, dwell 0
        set_req(0, 8'h0F, 8'hF0, 4'd0);
        req_valid = 2'b01;
        #1;
        chk("a_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("a_apply_busy", busy, 1'b1);
        chk("a_apply_q", q, 8'h00);
        chk("a_apply_ready", req_ready, 2'b00);
        chk("a_apply_done", done, 1'b0);
        tick();
        chk("a_q", q, 8'h0F);
        chk("a_qbar", qbar, 8'hF0);
        chk("a_busy_end", busy, 1'b0);
        chk("a_done", done, 1'b1);
        chk("a_done_id", done_id, 1'b0);
        tick();
        chk("a_done_pulse", done, 1'b0);

        // Toggle with dwell 3; req1 must wait for the done cycle
        set_req(0, 8'hFF, 8'hFF, 4'd3);
        set_req(1, 8'h00, 8'hFF, 4'd0);
        req_valid = 2'b01;
        #1;
        chk("b_ready0", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        #1;
        chk("b_apply_ready", req_ready, 2'b00);
        chk("b_apply_busy", busy, 1'b1);
        tick();
        chk("b_q", q, 8'hF0);
        chk("b_d3_busy", busy, 1'b1);
        chk("b_d3_ready", req_ready, 2'b00);
        tick();
        chk("b_d2_busy", busy, 1'b1);
        chk("b_d2_ready", req_ready, 2'b00);
        chk("b_d2_done", done, 1'b0);
        tick();
        chk("b_d1_busy", busy, 1'b1);
        chk("b_d1_ready", req_ready, 2'b00);
        tick();
        chk("b_busy_end", busy, 1'b0);
        chk("b_done", done, 1'b1);
        chk("b_done_id", done_id, 1'b0);
        chk("b_ready1", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("b1_apply_busy", busy, 1'b1);
        chk("b1_apply_done", done, 1'b0);
        tick();
        chk("b1_q", q, 8'h00);
        chk("b1_done", done, 1'b1);
        chk("b1_done_id", done_id, 1'b1);

        // Round robin, both continuously valid, dwell 0
        set_req(0, 8'h01, 8'h00, 4'd0);
        set_req(1, 8'h02, 8'h00, 4'd0);
        req_valid = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("c_grant", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("c_apply_busy", busy, 1'b1);
            chk("c_apply_ready", req_ready, 2'b00);
            tick();
            chk("c_done", done, 1'b1);
            chk("c_done_id", done_id, g % 2);
        end
        req_valid = 2'b00;
        chk("c_q", q, 8'h03);

        // Override collision on the APPLY edge, then preset during DWELL
        set_req(0, 8'hFF, 8'h00, 4'd2);
        req_valid = 2'b01;
        #1;
        chk("d_ready", req_ready, 2'b01);
        tick();
        req_valid   = 2'b00;
        sync_clr    = 1'b1;
        sync_preset = 1'b1;
        tick();
        chk("d_clr_wins_q", q, 8'h00);
        chk("d_clr_wins_qbar", qbar, 8'hFF);
        chk("d_dwell_busy", busy, 1'b1);
        sync_clr = 1'b0;
        tick();
        chk("d_preset_q", q, 8'hFF);
        chk("d_preset_busy", busy, 1'b1);
        chk("d_preset_done", done, 1'b0);
        sync_preset = 1'b0;
        tick();
        chk("d_busy_end", busy, 1'b0);
        chk("d_done", done, 1'b1);
        chk("d_done_id", done_id, 1'b0);
        chk("d_q_hold", q, 8'hFF);

        // Maximum dwell: 16 busy cycles in total
        set_req(1, 8'h00, 8'h00, 4'hF);
        req_valid = 2'b10;
        #1;
        chk("e_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("e_apply_busy", busy, 1'b1);
        for (int n = 1; n <= 15; n++) begin
            tick();
            chk("e_dwell_busy", busy, 1'b1);
            chk("e_dwell_done", done, 1'b0);
        end
        tick();
        chk("e_busy_end", busy, 1'b0);
        chk("e_done", done, 1'b1);
        chk("e_done_id", done_id, 1'b1);

        // Async reset mid-DWELL
        set_req(0, 8'hA5, 8'h5A, 4'd5);
        req_valid = 2'b01;
        #1;
        chk("f_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        chk("f_q", q, 8'hA5);
        tick();
        chk("f_dwell_busy", busy, 1'b1);
        req_valid = 2'b11;
        clr_n     = 1'b0;
        #1;
        chk("f_rst_q", q, 8'h00);
        chk("f_rst_qbar", qbar, 8'hFF);
        chk("f_rst_busy", busy, 1'b0);
        chk("f_rst_done", done, 1'b0);
        chk("f_rst_ready", req_ready, 2'b00);
        tick();
        set_req(0, 8'h3C, 8'h00, 4'd0);
        set_req(1, 8'hC3, 8'h00, 4'd0);
        clr_n = 1'b1;
        #1;
        chk("f_first_grant", req_ready, 2'b01);
        chk("f_no_done", done, 1'b0);
        tick();
        req_valid = 2'b00;
        chk("f_apply_busy", busy, 1'b1);
        tick();
        chk("f_q_after", q, 8'h3C);
        chk("f_done", done, 1'b1);
        chk("f_done_id", done_id, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Sequencer and arbiter for a shared bank of JK-style flip-flop bits. Up to NREQ requesters submit per-bit J/K update vectors over a valid/ready handshake. A round-robin arbiter grants one request at a time. The controller applies the JK update to the bank, then holds the bank locked for a requester-specified dwell time before accepting the next command. Synchronous bank-wide clear/preset overrides sit above all requests, mirroring single-FF clr/preset priority.

## Interface
- WIDTH, 8, number of bits in the bank
- NREQ, 2, number of requesters (2..8)
- DW, 4, width of dwell count

- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  grant/accept, one-hot or zero
- req_j  in  NREQ*WIDTH  J vector; requester i occupies bits [i*WIDTH +: WIDTH]
- req_k  in  NREQ*WIDTH  K vector, same packing as req_j
- req_dwell  in  NREQ*DW  lock cycles after apply; requester i occupies bits [i*DW +: DW]
- sync_clr  in  1  synchronous bank clear, highest priority
- sync_preset  in  1  synchronous bank preset, below sync_clr
- q  out  WIDTH  bank state
- qbar  out  WIDTH  always ~q
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse when a command completes
- done_id  out  $clog2(NREQ)  requester whose command completed; valid while done=1

## Operation
- FSM states: IDLE, APPLY, DWELL.
- **IDLE:** the arbiter picks a winner among the set req_valid bits, starting at rr_ptr and wrapping. req_ready[winner]=1 combinationally in the same cycle.
  - On the transfer edge the controller latches the winner's J, K, dwell and id, sets rr_ptr=(winner+1) mod NREQ, and goes to APPLY.
  - No valid requests: stay in IDLE, req_ready=0.
- **APPLY (1 cycle):** at the closing edge each bit updates: JK=00 hold, 01 clear, 10 set, 11 toggle.
  - Next state is DWELL if the latched dwell is nonzero, otherwise IDLE.
- **DWELL:** a counter loads the dwell value on APPLY exit and decrements once per cycle. When the count reaches 1, the next state is IDLE.
  - req_ready=0 in APPLY and DWELL.
- **done:** registered; high for exactly the first IDLE cycle after a command finishes. done_id holds the latched id.
- **Overrides:** sync_clr=1 sets q=0 at the next edge in any state. Otherwise sync_preset=1 sets q=all ones.
  - An override replaces the JK update if it lands on the APPLY edge.
  - An override does not alter FSM, dwell counter, done or rr_ptr.
- **Invariant:** qbar is derived from q, so qbar==~q always.
- **clr_n=0 (async, any time, including mid-DWELL):**
  - q=0, qbar=all ones, state=IDLE, rr_ptr=0, dwell counter=0.
  - done=0, done_id=0, busy=0, req_ready=0 (req_ready is forced to 0 while clr_n is low).
  - A command in flight is discarded with no done pulse.

## Timing
- Transfer at edge E0; q reflects the update after edge E1 (one cycle after the transfer edge).
- The FSM returns to IDLE at edge E1+dwell; done is high in the cycle after that edge.
- A new grant may occur in that same cycle, so back-to-back throughput is 2+dwell cycles per command.
- Dwell at its maximum (2^DW−1) must count without wrap; dwell=0 skips DWELL entirely.
- The arbiter is fair: a continuously valid requester waits at most NREQ−1 commands.
- Requesters must hold req_valid, J, K and dwell stable until req_ready; dropping req_valid early is legal and simply withdraws the request.
- busy=1 from the cycle after transfer through the last DWELL or APPLY cycle.

## Structure
- Shared package jk_pkg holds:
  - the FSM state enum (IDLE, APPLY, DWELL);
  - the JK opcode constants (JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11);
  - a function returning the next bit from q, j and k.
- One sub-module, rr_arbiter (parameter NREQ). Inputs: request vector, rr_ptr. Output: one-hot grant plus encoded index. It is purely combinational; rr_ptr lives in jk_bank_ctrl.

## Test plan
All scenarios use WIDTH=8, NREQ=2, DW=4.
- **Reset:** clr_n low mid-DWELL with q=8'hA5 → q=8'h00, qbar=8'hFF, busy=0, done=0 immediately; after release, the first grant goes to requester 0 when both are valid.
- **Single command:** req0 J=8'h0F, K=8'hF0, dwell=0 from q=8'h00 → req_ready[0] in cycle 0, q=8'h0F after edge E1, done=1 with done_id=0 in the next cycle, busy high for exactly 1 cycle.
- **Toggle plus dwell:** J=K=8'hFF, dwell=3 from q=8'h0F → q=8'hF0; busy for 4 cycles; req1 held valid throughout is not granted until the done cycle.
- **Round robin:** both requesters continuously valid with dwell=0 → grants alternate 0,1,0,1, one grant every 2 cycles.
- **Override collision:** sync_clr and sync_preset both high on the APPLY edge of J=8'hFF → q=8'h00 and done still pulses. Then sync_preset alone → q=8'hFF while the FSM is in DWELL, with the dwell count unaffected.
- **Max dwell:** dwell=4'hF → busy for exactly 16 cycles, no early return to IDLE.
